// File: rtl/ab_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ab_link_pkg
// Description : Shared definitions for the two-wire (a,b) symbol link.
// Revision    : 1.0 - initial release
// ============================================================================
package ab_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5,
        FAIL   = 3'd6
    } state_t;

    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_START = 2'b11;

    // Parity symbol carries the even-parity bit on a and its complement on b.
    function automatic logic [1:0] parity_sym(input logic p);
        return {p, ~p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ab_ack_timer.sv
`default_nettype none
// ============================================================================
// Module      : ab_ack_timer
// Description : Loadable saturating up-counter with clear and terminal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ab_ack_timer #(
    parameter int LIMIT = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          en,
    output logic          tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (ld) begin
            r_count <= ld_val;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/ab_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : ab_frame_tx
// Description : Serialises a W-bit word into framed (a,b) symbols and
//               retransmits on nack or ack timeout up to MAX_RETRY times.
// Revision    : 1.0 - initial release
// ============================================================================
module ab_frame_tx
    import ab_link_pkg::*;
#(
    parameter int W           = 8,
    parameter int MAX_RETRY   = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] data,
    input  logic         m,
    input  logic         n,
    output logic         a,
    output logic         b,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int IW = (W > 2) ? $clog2(W / 2) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [IW-1:0] c_last_idx  = IW'(W / 2 - 1);
    localparam logic [RW-1:0] c_max_retry = RW'(MAX_RETRY);

    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_idx, w_idx_nx;
    logic [RW-1:0] r_retry, w_retry_nx;
    logic [W-1:0]  r_word, w_word_nx;
    logic [W-1:0]  w_shifted;
    logic [1:0]    w_sym_nx;
    logic          w_retry_chk;
    logic          w_t_clr, w_t_ld, w_t_en, w_t_tc;
    logic          r_a, r_b, r_busy, r_done, r_err;

    ab_ack_timer #(
        .LIMIT (ACK_TIMEOUT),
        .CW    (TW)
    ) u_ack_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (w_t_clr),
        .ld     (w_t_ld),
        .ld_val ('0),
        .en     (w_t_en),
        .tc     (w_t_tc)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_retry_nx  = r_retry;
        w_word_nx   = r_word;
        w_retry_chk = 1'b0;
        w_t_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_word_nx  = data;
                    w_retry_nx = '0;
                    w_state_nx = START;
                end
            end
            START: begin
                w_idx_nx   = '0;
                w_state_nx = DATA;
            end
            DATA: begin
                if (r_idx == c_last_idx) begin
                    w_state_nx = PARITY;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            PARITY: w_state_nx = WAIT;
            WAIT: begin
                if (m) begin
                    w_state_nx = DONE;
                end else if (n || w_t_tc) begin
                    w_retry_chk = 1'b1;
                end else begin
                    w_t_en = 1'b1;
                end
            end
            DONE:    w_state_nx = IDLE;
            FAIL:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        // Nack and timeout share one decision: resend the whole frame or give up.
        if (w_retry_chk) begin
            if (r_retry < c_max_retry) begin
                w_retry_nx = r_retry + 1'b1;
                w_state_nx = START;
            end else begin
                w_state_nx = FAIL;
            end
        end
    end

    assign w_t_clr = (w_state_nx == START) && (r_state != START);
    assign w_t_ld  = (w_state_nx == WAIT) && (r_state != WAIT);

    // Outputs are decoded from the next state so they line up with the state register.
    assign w_shifted = w_word_nx << {w_idx_nx, 1'b0};

    always_comb begin
        w_sym_nx = SYM_IDLE;
        case (w_state_nx)
            START:   w_sym_nx = SYM_START;
            DATA:    w_sym_nx = w_shifted[W-1 -: 2];
            PARITY:  w_sym_nx = parity_sym(^w_word_nx);
            default: w_sym_nx = SYM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_retry <= '0;
            r_word  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_retry <= w_retry_nx;
            r_word  <= w_word_nx;
            r_a     <= w_sym_nx[1];
            r_b     <= w_sym_nx[0];
            r_busy  <= (w_state_nx != IDLE);
            r_done  <= (w_state_nx == DONE);
            r_err   <= (w_state_nx == FAIL);
        end
    end

    assign a    = r_a;
    assign b    = r_b;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ab_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_frame_tx
// Description : Directed self-checking bench for ab_frame_tx (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_frame_tx;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic [7:0] data;
    logic       m;
    logic       n;
    logic       a, b, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    ab_frame_tx #(
        .W           (8),
        .MAX_RETRY   (2),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .data  (data),
        .m     (m),
        .n     (n),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_start(input logic [7:0] word);
        data  = word;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks the six frame symbols starting in the START cycle; ends in the PARITY cycle.
    task automatic frame_body(input logic [11:0] syms, input bit noise, input logic [7:0] word);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("sym%0d", i), {6'd0, a, b}, {6'd0, syms[11-2*i -: 2]});
            chk($sformatf("busy_f%0d", i), {7'd0, busy}, 8'd1);
            if (i < 5) begin
                if (noise && i < 3) begin
                    start = 1'b1; data = ~word; m = 1'b1; n = 1'b1;
                end else if (noise) begin
                    start = 1'b0; data = word; m = 1'b0; n = 1'b0;
                end
                tick();
            end
        end
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        m     = 1'b0;
        n     = 1'b0;
        #3;
        rst_b = 1'b1;
        #1;
        chk("rst_ab",   {6'd0, a, b}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_err",  {7'd0, err},  8'd0);
        tick();
        tick();
        chk("idle_hold_busy", {7'd0, busy}, 8'd0);
        chk("idle_hold_ab",   {6'd0, a, b}, 8'd0);

        // Basic frame A5: 11,10,10,01,01, parity 0 -> 01
        issue_start(8'hA5);
        frame_body(12'b11_10_10_01_01_01, 1'b0, 8'hA5);
        m = 1'b1;
        tick();
        chk("a5_wait_ab",   {6'd0, a, b}, 8'd0);
        chk("a5_wait_done", {7'd0, done}, 8'd0);
        tick();
        m = 1'b0;
        chk("a5_done",      {7'd0, done}, 8'd1);
        chk("a5_done_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("a5_idle_done", {7'd0, done}, 8'd0);
        chk("a5_idle_busy", {7'd0, busy}, 8'd0);

        // Nack twice then ack, 3C: 11,00,11,11,00, parity 0 -> 01
        issue_start(8'h3C);
        for (int r = 0; r < 2; r++) begin
            frame_body(12'b11_00_11_11_00_01, 1'b0, 8'h3C);
            n = 1'b1;
            tick();
            chk("3c_wait_ab", {6'd0, a, b}, 8'd0);
            tick();
            n = 1'b0;
            chk("3c_no_err", {7'd0, err}, 8'd0);
        end
        frame_body(12'b11_00_11_11_00_01, 1'b0, 8'h3C);
        m = 1'b1;
        tick();
        tick();
        m = 1'b0;
        chk("3c_done", {7'd0, done}, 8'd1);
        chk("3c_err",  {7'd0, err},  8'd0);
        tick();
        chk("3c_idle_done", {7'd0, done}, 8'd0);

        // Timeout exhaustion, FF: 11,11,11,11,11, parity 0 -> 01
        issue_start(8'hFF);
        for (int r = 0; r < 3; r++) begin
            frame_body(12'b11_11_11_11_11_01, 1'b0, 8'hFF);
            for (int j = 0; j < 8; j++) begin
                tick();
                chk($sformatf("to_wait%0d_ab", j), {6'd0, a, b}, 8'd0);
                chk($sformatf("to_wait%0d_busy", j), {7'd0, busy}, 8'd1);
                chk($sformatf("to_wait%0d_err", j), {7'd0, err}, 8'd0);
            end
            tick();
        end
        chk("to_err",      {7'd0, err},  8'd1);
        chk("to_err_done", {7'd0, done}, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_idle_err",  {7'd0, err},  8'd0);
        chk("to_idle_busy", {7'd0, busy}, 8'd0);
        tick();
        chk("to_ignored_start", {7'd0, busy}, 8'd0);

        // m and n both high in WAIT; start/data/m/n noise mid-frame. 01: 11,00,00,00,01, parity 1 -> 10
        issue_start(8'h01);
        frame_body(12'b11_00_00_00_01_10, 1'b1, 8'h01);
        m = 1'b1;
        n = 1'b1;
        tick();
        chk("pri_wait_ab", {6'd0, a, b}, 8'd0);
        tick();
        m = 1'b0;
        n = 1'b0;
        chk("pri_done", {7'd0, done}, 8'd1);
        chk("pri_ab",   {6'd0, a, b}, 8'd0);
        tick();
        chk("pri_idle", {7'd0, busy}, 8'd0);

        // Async reset mid-DATA, 96: 11,10,01,01,10, parity 0 -> 01
        issue_start(8'h96);
        tick();
        tick();
        chk("rst_mid_sym", {6'd0, a, b}, 8'b01);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_ab",   {6'd0, a, b}, 8'd0);
        chk("rst_mid_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        chk("rst_post_done", {7'd0, done}, 8'd0);
        chk("rst_post_err",  {7'd0, err},  8'd0);
        chk("rst_post_busy", {7'd0, busy}, 8'd0);
        issue_start(8'h96);
        frame_body(12'b11_10_01_01_10_01, 1'b0, 8'h96);
        m = 1'b1;
        tick();
        tick();
        m = 1'b0;
        chk("rst_clean_done", {7'd0, done}, 8'd1);
        tick();
        chk("rst_clean_idle", {7'd0, busy}, 8'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
